// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the cache pmem port, the cacheline adaptor and burst memory.
// slave = adaptor view, master = the cache/memory environment driving the inputs.
`timescale 1ns/1ps
interface cacheline_adaptor_if #(
    parameter int BEAT_W    = 64,
    parameter int NUM_BEATS = 4
);
    localparam int LINE_W = BEAT_W * NUM_BEATS;

    // cache side
    logic [LINE_W-1:0] line_i;
    logic [LINE_W-1:0] line_o;
    logic [31:0]       address_i;
    logic              read_i;
    logic              write_i;
    logic              resp_o;
    logic              err_o;

    // burst memory side
    logic [BEAT_W-1:0] burst_i;
    logic [BEAT_W-1:0] burst_o;
    logic [31:0]       address_o;
    logic              read_o;
    logic              write_o;
    logic              resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, err_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, err_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Cache line <-> 4-beat burst adaptor; CLA_TIMEOUT_EN adds a per-beat stall timeout (err_o).
// Zero-wait latency: request edge, 4 beat cycles, 1 resp_o cycle; resp_i=0 stalls a beat.
`timescale 1ns/1ps
module cacheline_adaptor #(
    parameter int BEAT_W         = 64,
    parameter int NUM_BEATS      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    cacheline_adaptor_if.slave   bus
);
    localparam int LINE_W = BEAT_W * NUM_BEATS;
    localparam int CNT_W  = $clog2(NUM_BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);

    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [31:0]       r_addr;
    logic [LINE_W-1:0] r_rline;
    logic [LINE_W-1:0] r_wline;
    logic [BEAT_W-1:0] w_wbeat;
    logic              w_last;
    logic              w_busy;
    logic              w_timeout;

    assign w_last = (r_count == LAST_BEAT);
    assign w_busy = (r_state == S_READ) || (r_state == S_WRITE);

`ifdef CLA_TIMEOUT_EN
    logic [7:0] r_stall;
    logic       r_err;

    assign w_timeout = w_busy && !bus.resp_i && (r_stall == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_busy && !bus.resp_i)
                r_stall <= r_stall + 8'd1;
            else
                r_stall <= 8'd0;

            if (w_timeout)
                r_err <= 1'b1;
            else if (r_state == S_DONE)
                r_err <= 1'b0;
        end
    end

    assign bus.err_o = r_err && (r_state == S_DONE);
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = ^32'(TIMEOUT_CYCLES);
    assign bus.err_o    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_addr  <= 32'd0;
            r_rline <= '0;
            r_wline <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // read takes priority when both requests arrive together
                    if (bus.read_i) begin
                        r_state <= S_READ;
                        r_addr  <= bus.address_i & ADDR_MASK;
                        r_count <= '0;
                    end else if (bus.write_i) begin
                        r_state <= S_WRITE;
                        r_addr  <= bus.address_i & ADDR_MASK;
                        r_wline <= bus.line_i;
                        r_count <= '0;
                    end
                end
                S_READ: begin
                    if (w_timeout) begin
                        r_state <= S_DONE;
                    end else if (bus.resp_i) begin
                        for (int b = 0; b < NUM_BEATS; b++) begin
                            if (r_count == CNT_W'(b))
                                r_rline[b*BEAT_W +: BEAT_W] <= bus.burst_i;
                        end
                        r_count <= r_count + CNT_W'(1);
                        if (w_last)
                            r_state <= S_DONE;
                    end
                end
                S_WRITE: begin
                    if (w_timeout) begin
                        r_state <= S_DONE;
                    end else if (bus.resp_i) begin
                        r_count <= r_count + CNT_W'(1);
                        if (w_last)
                            r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // current write beat selected straight from the count so it tracks each acceptance
    always_comb begin
        w_wbeat = '0;
        for (int b = 0; b < NUM_BEATS; b++) begin
            if (r_count == CNT_W'(b))
                w_wbeat = r_wline[b*BEAT_W +: BEAT_W];
        end
    end

    assign bus.read_o    = (r_state == S_READ);
    assign bus.write_o   = (r_state == S_WRITE);
    assign bus.resp_o    = (r_state == S_DONE);
    assign bus.address_o = r_addr;
    assign bus.line_o    = r_rline;
    assign bus.burst_o   = (r_state == S_WRITE) ? w_wbeat : '0;

endmodule
